// File: rtl/piece_lock_clear.sv
// piece_lock_clear: locks a landed tetromino into the board RAM, then
// scans the board bottom-up, clears full rows by shifting the rows above
// them down by one, and reports how many lines were cleared.
// Optional feature: define TETRIS_SCORE_EN to build the running score
// register; otherwise score is tied to zero.

module piece_lock_clear #(
  parameter int BOARD_W     = 10,
  parameter int BOARD_H     = 24,
  parameter int HIDDEN_ROWS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  X_anchor,
  input  logic [5:0]  Y_anchor,
  input  logic [2:0]  block,
  input  logic [5:0]  ram_Q,
  output logic [7:0]  ram_addr,
  output logic [5:0]  ram_data,
  output logic        ram_wren,
  output logic        busy,
  output logic        done,
  output logic [2:0]  lines_cleared,
  output logic        game_over,
  output logic [15:0] score
);

  localparam int RW = $clog2(BOARD_H);
  localparam logic [7:0] W8 = 8'(BOARD_W);

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    SCAN,
    SHIFT,
    CLEARTOP,
    FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           phase_q, phase_d;
  logic [RW-1:0]  row_q, row_d;
  logic [RW-1:0]  shift_q, shift_d;
  logic [2:0]     lines_cnt_q, lines_cnt_d;
  logic [2:0]     lines_q, lines_d;
  logic           full_q, full_d;
  logic           game_over_q, game_over_d;
  logic [4:0]     x_q, x_d;
  logic [5:0]     y_q, y_d;
  logic [2:0]     blk_q, blk_d;

  logic [7:0]     coord_x;
  logic [7:0]     coord_y;
  logic [5:0]     colour;
  logic [1:0]     off_x;
  logic [1:0]     off_y;
  logic [7:0]     cell_row;
  logic [7:0]     cell_col;
  logic [7:0]     lock_addr;
  logic [3:0]     scan_col;
  logic           row_full;

  // Piece shapes at rotation 0: {colour, coord_y, coord_x}, offset i in bits [2i+1:2i].
  function automatic logic [21:0] piece_lut(input logic [2:0] b);
    case (b)
      3'd0:    return {6'd1, 8'h00, 8'hE4};  // I, horizontal
      3'd1:    return {6'd2, 8'hE4, 8'h00};  // I, vertical
      3'd2:    return {6'd3, 8'h50, 8'h44};  // O
      3'd3:    return {6'd4, 8'h40, 8'h64};  // T
      3'd4:    return {6'd5, 8'h50, 8'h49};  // S
      3'd5:    return {6'd6, 8'h50, 8'h94};  // Z
      3'd6:    return {6'd7, 8'h54, 8'h90};  // J
      default: return {6'd8, 8'h54, 8'h92};  // L
    endcase
  endfunction

  // First RAM address of a board row.
  function automatic logic [7:0] row_base(input logic [RW-1:0] r);
    return 8'(r) * W8;
  endfunction

  // Decode the latched piece and the cell currently being locked.
  always_comb begin
    {colour, coord_y, coord_x} = piece_lut(blk_q);
    off_x     = coord_x[{cnt_q[1:0], 1'b0} +: 2];
    off_y     = coord_y[{cnt_q[1:0], 1'b0} +: 2];
    cell_row  = 8'(y_q) + 8'(off_y);
    cell_col  = 8'(x_q) + 8'(off_x);
    lock_addr = cell_row * W8 + cell_col;
    scan_col  = (cnt_q == 4'(BOARD_W)) ? 4'(BOARD_W - 1) : cnt_q;
    row_full  = full_q & (ram_Q != 6'd0);
  end

  // Controller: next state, counters and the RAM port for the current cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    row_d       = row_q;
    shift_d     = shift_q;
    lines_cnt_d = lines_cnt_q;
    lines_d     = lines_q;
    full_d      = full_q;
    game_over_d = game_over_q;
    x_d         = x_q;
    y_d         = y_q;
    blk_d       = blk_q;
    ram_addr    = 8'd0;
    ram_data    = 6'd0;
    ram_wren    = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d         = X_anchor;
          y_d         = Y_anchor;
          blk_d       = block;
          lines_cnt_d = 3'd0;
          cnt_d       = 4'd0;
          state_d     = LOCK;
        end
      end

      LOCK: begin
        ram_addr = lock_addr;
        ram_data = colour;
        ram_wren = 1'b1;
        if (cell_row < 8'(HIDDEN_ROWS)) begin
          game_over_d = 1'b1;
        end
        if (cnt_q == 4'd3) begin
          cnt_d   = 4'd0;
          row_d   = RW'(BOARD_H - 1);
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SCAN: begin
        // Read data lags the address by one cycle, so the verdict for the
        // row is available on the extra eleventh cycle.
        ram_addr = row_base(row_q) + 8'(scan_col);
        full_d   = (cnt_q == 4'd0) ? 1'b1 : row_full;
        if (cnt_q == 4'(BOARD_W)) begin
          cnt_d   = 4'd0;
          phase_d = 1'b0;
          if (row_full) begin
            if (lines_cnt_q != 3'd4) begin
              lines_cnt_d = lines_cnt_q + 3'd1;
            end
            if (row_q == '0) begin
              state_d = CLEARTOP;
            end else begin
              shift_d = row_q;
              state_d = SHIFT;
            end
          end else if (row_q == '0) begin
            lines_d = lines_cnt_q;
            state_d = FINISH;
          end else begin
            row_d = row_q - RW'(1);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SHIFT: begin
        if (!phase_q) begin
          ram_addr = row_base(shift_q - RW'(1)) + 8'(cnt_q);
          phase_d  = 1'b1;
        end else begin
          ram_addr = row_base(shift_q) + 8'(cnt_q);
          ram_data = ram_Q;
          ram_wren = 1'b1;
          phase_d  = 1'b0;
          if (cnt_q == 4'(BOARD_W - 1)) begin
            cnt_d   = 4'd0;
            shift_d = shift_q - RW'(1);
            if (shift_q == RW'(1)) begin
              state_d = CLEARTOP;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      CLEARTOP: begin
        // The row that dropped into the cleared slot must be rechecked,
        // so the scan resumes on the same row.
        ram_addr = 8'(cnt_q);
        ram_data = 6'd0;
        ram_wren = 1'b1;
        if (cnt_q == 4'(BOARD_W - 1)) begin
          cnt_d   = 4'd0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      phase_q     <= 1'b0;
      row_q       <= '0;
      shift_q     <= '0;
      lines_cnt_q <= 3'd0;
      lines_q     <= 3'd0;
      full_q      <= 1'b0;
      game_over_q <= 1'b0;
      x_q         <= 5'd0;
      y_q         <= 6'd0;
      blk_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      row_q       <= row_d;
      shift_q     <= shift_d;
      lines_cnt_q <= lines_cnt_d;
      lines_q     <= lines_d;
      full_q      <= full_d;
      game_over_q <= game_over_d;
      x_q         <= x_d;
      y_q         <= y_d;
      blk_q       <= blk_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign lines_cleared = lines_q;
  assign game_over     = game_over_q;

`ifdef TETRIS_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [3:0]  points;
  logic [16:0] score_sum;

  // Award points on entry to FINISH so the new total is visible with done.
  always_comb begin
    case (lines_cnt_q)
      3'd1:    points = 4'd1;
      3'd2:    points = 4'd3;
      3'd3:    points = 4'd5;
      3'd4:    points = 4'd8;
      default: points = 4'd0;
    endcase
    score_sum = {1'b0, score_q} + 17'(points);
    score_d   = score_q;
    if (state_q == SCAN && state_d == FINISH) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  // Score register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= 16'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

endmodule

// File: tb/tb_piece_lock_clear.sv
// Bench for piece_lock_clear: a board RAM model, a board-level reference
// model of lock/clear/score behaviour, directed scenarios and randomized
// locks on randomly prefilled boards.

module tb_piece_lock_clear;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  X_anchor;
  logic [5:0]  Y_anchor;
  logic [2:0]  block;
  logic [5:0]  ram_Q;
  logic [7:0]  ram_addr;
  logic [5:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        done;
  logic [2:0]  lines_cleared;
  logic        game_over;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piece_lock_clear dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .X_anchor      (X_anchor),
    .Y_anchor      (Y_anchor),
    .block         (block),
    .ram_Q         (ram_Q),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .game_over     (game_over),
    .score         (score)
  );

  // Board RAM with a row-wide backdoor load port for board setup.
  logic [5:0] mem [0:239];
  logic       bd_we = 1'b0;
  int         bd_row = 0;
  logic [5:0] bd_vals [10];
  int         write_cnt = 0;
  int         done_cnt = 0;

  always @(posedge clk) begin
    if (bd_we) begin
      for (int c = 0; c < 10; c++) mem[bd_row*10 + c] <= bd_vals[c];
    end else if (ram_wren && ram_addr < 8'd240) begin
      mem[ram_addr] <= ram_data;
    end
    ram_Q <= (ram_addr < 8'd240) ? mem[ram_addr] : 6'd0;
    if (ram_wren) write_cnt <= write_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Piece shapes as cell lists (column offset, row offset) and colours.
  int px [8][4] = '{'{0,1,2,3}, '{0,0,0,0}, '{0,1,0,1}, '{0,1,2,1},
                    '{1,2,0,1}, '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
  int py [8][4] = '{'{0,0,0,0}, '{0,1,2,3}, '{0,0,1,1}, '{0,0,0,1},
                    '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};
  int pc [8]    = '{1,2,3,4,5,6,7,8};
  int pts [5]   = '{0,1,3,5,8};

  // Reference board and sticky state.
  int mb [24][10];
  int mgo = 0;
  int mscore = 0;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 10; c++) mb[r][c] = 0;
  endtask

  function automatic bit model_row_full(input int r);
    for (int c = 0; c < 10; c++) if (mb[r][c] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Lock a piece and clear rows the way the game defines it; also predict
  // cycle count (start cycle through done cycle inclusive) and RAM writes.
  task automatic model_lock(input int x, input int y, input int b,
                            output int lines, output int cyc, output int wr);
    int r;
    for (int i = 0; i < 4; i++) begin
      mb[y + py[b][i]][x + px[b][i]] = pc[b];
      if (y + py[b][i] < 2) mgo = 1;
    end
    lines = 0;
    cyc   = 270;
    wr    = 4;
    r     = 23;
    while (r >= 0) begin
      if (model_row_full(r)) begin
        for (int rr = r; rr >= 1; rr--)
          for (int c = 0; c < 10; c++) mb[rr][c] = mb[rr-1][c];
        for (int c = 0; c < 10; c++) mb[0][c] = 0;
        if (lines < 4) lines++;
        cyc += 20*r + 10 + 11;
        wr  += 10*r + 10;
      end else begin
        r--;
      end
    end
    mscore = mscore + pts[lines];
    if (mscore > 65535) mscore = 65535;
  endtask

  // Copy the reference board into the RAM model through the backdoor.
  task automatic load_board();
    for (int r = 0; r < 24; r++) begin
      bd_row = r;
      for (int c = 0; c < 10; c++) bd_vals[c] = 6'(mb[r][c]);
      bd_we = 1'b1;
      tick();
    end
    bd_we = 1'b0;
    tick();
  endtask

  task automatic compare_board(input string tag);
    int bad = 0;
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 10; c++)
        if (mem[r*10 + c] !== 6'(mb[r][c])) bad++;
    check_output(tag, 32'(bad), 32'd0);
  endtask

  // Run one lock from IDLE and check timing, results and the final board.
  task automatic apply_stimulus(input int x, input int y, input int b,
                                input bit poke, input string tag);
    int exp_lines, exp_cyc, exp_wr, n, w0, d0;
    logic [15:0] exp_score;
    model_lock(x, y, b, exp_lines, exp_cyc, exp_wr);
`ifdef TETRIS_SCORE_EN
    exp_score = 16'(mscore);
`else
    exp_score = 16'd0;
`endif
    w0 = write_cnt;
    d0 = done_cnt;
    X_anchor = 5'(x);
    Y_anchor = 6'(y);
    block    = 3'(b);
    start    = 1'b1;
    tick();
    start = 1'b0;
    check_output({tag, "_busy_rise"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 6000) begin
      if (poke) start = (n == 3 || n == 150 || n == 260);
      tick();
      n++;
    end
    start = 1'b0;
    check_output({tag, "_latency"}, 32'(n + 2), 32'(exp_cyc));
    check_output({tag, "_lines"}, 32'(lines_cleared), 32'(exp_lines));
    check_output({tag, "_game_over"}, 32'(game_over), 32'(mgo));
    check_output({tag, "_score"}, 32'(score), 32'(exp_score));
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
    tick();
    check_output({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check_output({tag, "_writes"}, 32'(write_cnt - w0), 32'(exp_wr));
    check_output({tag, "_lines_held"}, 32'(lines_cleared), 32'(exp_lines));
    compare_board({tag, "_board"});
  endtask

  function automatic logic [5:0] rand_colour();
    return 6'($urandom_range(1, 8));
  endfunction

  initial begin
    int b, x, y, w, h;
    reset    = 1'b1;
    start    = 1'b0;
    X_anchor = 5'd0;
    Y_anchor = 6'd0;
    block    = 3'd0;
    for (int c = 0; c < 10; c++) bd_vals[c] = 6'd0;
    repeat (3) tick();

    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rst_ram_data", 32'(ram_data), 32'd0);
    check_output("rst_ram_wren", 32'(ram_wren), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_lines", 32'(lines_cleared), 32'd0);
    check_output("rst_game_over", 32'(game_over), 32'd0);
    check_output("rst_score", 32'(score), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] empty board, horizontal bar at (0,23)");
    clear_model();
    load_board();
    apply_stimulus(0, 23, 0, 1'b0, "empty");

    $display("[TB] single line clear");
    clear_model();
    for (int c = 4; c < 10; c++) mb[23][c] = rand_colour();
    for (int c = 0; c < 10; c++) mb[22][c] = ($urandom_range(0, 1) != 0) ? rand_colour() : 0;
    mb[22][$urandom_range(0, 9)] = 0;
    mb[5][3] = 4;
    load_board();
    apply_stimulus(0, 23, 0, 1'b0, "one_line");

    $display("[TB] four line clear with vertical bar");
    clear_model();
    for (int r = 20; r < 24; r++)
      for (int c = 1; c < 10; c++) mb[r][c] = rand_colour();
    for (int r = 16; r < 20; r++) begin
      for (int c = 0; c < 10; c++) mb[r][c] = ($urandom_range(0, 1) != 0) ? rand_colour() : 0;
      mb[r][$urandom_range(0, 9)] = 0;
    end
    load_board();
    apply_stimulus(0, 20, 1, 1'b1, "tetris");

    $display("[TB] game over is sticky");
    apply_stimulus(4, 1, 2, 1'b0, "spawn_lock");
    apply_stimulus(2, 10, 3, 1'b0, "after_go");

    $display("[TB] reset during shift");
    clear_model();
    for (int c = 4; c < 10; c++) mb[23][c] = rand_colour();
    load_board();
    X_anchor = 5'd0;
    Y_anchor = 6'd23;
    block    = 3'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check_output("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_wren", 32'(ram_wren), 32'd0);
    check_output("async_busy", 32'(busy), 32'd0);
    check_output("async_addr", 32'(ram_addr), 32'd0);
    check_output("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    mgo    = 0;
    mscore = 0;
    clear_model();
    load_board();
    apply_stimulus(3, 22, 6, 1'b0, "post_reset");

    $display("[TB] randomized locks");
    for (int k = 0; k < 8; k++) begin
      clear_model();
      b = $urandom_range(0, 7);
      w = 0;
      h = 0;
      for (int i = 0; i < 4; i++) begin
        if (px[b][i] + 1 > w) w = px[b][i] + 1;
        if (py[b][i] + 1 > h) h = py[b][i] + 1;
      end
      x = $urandom_range(0, 10 - w);
      y = ($urandom_range(0, 2) != 0) ? 24 - h : $urandom_range(2, 24 - h);
      for (int r = 20; r < 24; r++) begin
        for (int c = 0; c < 10; c++) mb[r][c] = rand_colour();
        if ($urandom_range(0, 3) == 0) mb[r][$urandom_range(0, 9)] = 0;
      end
      for (int i = 0; i < 4; i++)
        if (y + py[b][i] >= 20) mb[y + py[b][i]][x + px[b][i]] = 0;
      for (int r = 12; r < 20; r++)
        for (int c = 0; c < 10; c++)
          if ($urandom_range(0, 3) == 0) mb[r][c] = rand_colour();
      load_board();
      apply_stimulus(x, y, b, (k == 7), $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_lock_clear.md
# piece_lock_clear

Post-landing stage of the playfield pipeline, downstream of the collision checker. When a falling tetromino reports a downward collision, this block writes the piece's four cells into the board RAM. It then scans the 10×24 board bottom-up for full rows, clears each one by shifting all rows above it down by one, and reports the number of lines cleared. A game-over condition is flagged when the piece locks in a hidden spawn row.

## Interface
Parameters:
- BOARD_W, 10, columns per row; RAM address = row*BOARD_W + col
- BOARD_H, 24, rows; row 0 is the top
- HIDDEN_ROWS, 2, rows 0..HIDDEN_ROWS-1 are spawn rows; locking any cell there raises game_over

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  one-cycle request to lock the piece; sampled only in IDLE
- X_anchor  in  5  piece anchor column
- Y_anchor  in  6  piece anchor row
- block  in  3  piece type; decoded through lut (rotation 2'b00) into coord_x[7:0], coord_y[7:0] (four 2-bit offsets each) and colour[5:0]
- ram_Q  in  6  board RAM read data; reflects the address driven in the previous cycle; 0 = empty
- ram_addr  out  8  board RAM address
- ram_data  out  6  board RAM write data
- ram_wren  out  1  board RAM write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- lines_cleared  out  3  rows cleared by the last lock (0..4); valid with done, held until next start
- game_over  out  1  sticky; cleared only by reset
- score  out  16  running score (see Configuration)

## Operation
- Reset values: ram_addr=0, ram_data=0, ram_wren=0, busy=0, done=0, lines_cleared=0, game_over=0, score=0, state=IDLE.
- IDLE: on start=1, latch X_anchor, Y_anchor and block; clear the line counter; go to LOCK. start in any other state is ignored.
- LOCK (4 cycles, i=0..3): ram_addr=(Y+coord_y[2i+1:2i])*10 + X+coord_x[2i+1:2i], ram_data=colour, ram_wren=1. If any cell row < HIDDEN_ROWS, set game_over. Then r=23 and go to SCAN.
- SCAN row r (11 cycles): drive addresses r*10+0..9 on consecutive cycles. Sample ram_Q one cycle later. full = AND of (ram_Q≠0) over all 10 cells.
  - If full: increment the line counter (saturate at 4) and go to SHIFT with s=r.
  - Else if r=0: go to FINISH.
  - Else: r=r-1 and SCAN again.
- SHIFT row s≥1: for each col c=0..9, spend 2 cycles:
  - read cycle: ram_addr=(s-1)*10+c, ram_wren=0
  - write cycle: ram_addr=s*10+c, ram_data=ram_Q, ram_wren=1
  - After col 9, s=s-1; when s=0 go to CLEARTOP.
- CLEARTOP (10 cycles): write 0 to addresses 0..9. Return to SCAN on the same r, because the row shifted into it must be rechecked.
- FINISH: done=1 for one cycle, lines_cleared=counter, busy=0, return to IDLE.
- Arithmetic: row*10+col is computed in 8 bits, so the maximum address is 239. Piece cell coordinates use anchor+offset without wrap; the upstream stage guarantees they are in range.
- ram_wren is 0 in every state and cycle not listed above.

## Timing
- Total latency from start to done = 1 + 4 + 24×11 + F×(20×s_rows + 10 + 11) + 1 cycles, where F is the number of full rows.
  - s_rows is the number of rows above each cleared row (equal to its row index).
  - With no full rows this is 270 cycles.
- busy rises the cycle after start and falls the cycle after done.
- reset mid-operation: outputs return to reset values immediately (asynchronously). Board RAM contents may be partially updated; the controller must clear the board before reuse.
- start asserted in the same cycle as done is ignored; it is accepted only from IDLE on the following cycle.

## Configuration
- TETRIS_SCORE_EN defined: at FINISH, score += 0/1/3/5/8 for 0/1/2/3/4 lines. The add saturates at 16'hFFFF and takes effect in the done cycle.
- Not defined: no score register is built and score is tied to 0.

## Test plan
- Empty board; lock a horizontal 4-cell bar at anchor (0,23) -> 4 writes of colour to addresses 230..233, no other writes; done after 270 cycles with lines_cleared=0.
- Row 23 cols 4..9 prefilled; lock the bar at (0,23) -> row 23 cleared; row 22 contents copied into 23, row 0 zeroed; lines_cleared=1; score=1 when TETRIS_SCORE_EN.
- Rows 20..23 all full except col 0; lock a vertical 4-cell bar at (0,20) -> 4 rows cleared, rows 20..23 hold the former rows 16..19, lines_cleared=4; score +8.
- Lock a piece with a cell at row 1 -> game_over=1 and stays 1 across subsequent locks until reset.
- Assert reset during SHIFT -> ram_wren=0, busy=0, state IDLE in the same cycle. A new start is then accepted normally.
- Pulse start while busy -> ignored: no extra writes, single done pulse.
